// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the prescaled UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_bit_timer
// Brief    : Bit-period counter; pulses o_bit_done on the last cycle of a bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_enable,
    input  logic [PRESCALE_WIDTH-1:0] i_eff,
    output logic                      o_bit_done
);

    localparam logic [PRESCALE_WIDTH-1:0] c_ONE = PRESCALE_WIDTH'(1);

    logic [PRESCALE_WIDTH-1:0] r_cnt;

    assign o_bit_done = i_enable && (r_cnt == (i_eff - c_ONE));

    // Held at zero while idle so a freshly launched frame starts its count at 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_enable || o_bit_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_prescaled.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_prescaled
// Brief    : UART transmitter (start, 8 data LSB first, optional parity, stop),
//            each bit held for Prescale clocks. Option macro:
//            UART_TX_HOLD_BUF_EN adds a one-entry holding register.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_prescaled #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    import uart_pkg::*;

    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_e                 r_state, w_state_next;
    logic [DATA_WIDTH-1:0]     r_shift, w_shift_next;
    logic [c_IDX_W-1:0]        r_idx, w_idx_next;
    logic                      r_par_en, w_par_en_next;
    logic                      r_par, w_par_next;
    logic [PRESCALE_WIDTH-1:0] r_eff, w_eff_next;
    logic                      r_tx, w_tx_next;
    logic                      r_busy, w_busy_next;
    logic                      w_bit_done;
    logic                      w_launch;

    logic                      w_src_valid;
    logic [DATA_WIDTH-1:0]     w_src_data;
    logic                      w_src_par_en;
    logic                      w_src_par_typ;
    logic [PRESCALE_WIDTH-1:0] w_src_prescale;

    // A new frame may launch from idle or on the final edge of a stop bit.
    assign w_launch = ((r_state == IDLE) || ((r_state == STOP) && w_bit_done)) && w_src_valid;

`ifdef UART_TX_HOLD_BUF_EN
    logic                      r_hold_full, w_hold_full_next;
    logic [DATA_WIDTH-1:0]     r_hold_data;
    logic                      r_hold_par_en;
    logic                      r_hold_par_typ;
    logic [PRESCALE_WIDTH-1:0] r_hold_prescale;
    logic                      w_hold_load;

    assign w_src_valid    = r_hold_full || DATA_VALID;
    assign w_src_data     = r_hold_full ? r_hold_data     : P_DATA;
    assign w_src_par_en   = r_hold_full ? r_hold_par_en   : PAR_EN;
    assign w_src_par_typ  = r_hold_full ? r_hold_par_typ  : PAR_TYP;
    assign w_src_prescale = r_hold_full ? r_hold_prescale : Prescale;

    // Inputs consumed directly by a launch never pass through the buffer.
    assign w_hold_load      = DATA_VALID && !r_hold_full && !w_launch;
    assign w_hold_full_next = r_hold_full ? !w_launch : w_hold_load;
    assign w_busy_next      = w_hold_full_next;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_hold_full     <= 1'b0;
            r_hold_data     <= '0;
            r_hold_par_en   <= 1'b0;
            r_hold_par_typ  <= 1'b0;
            r_hold_prescale <= '0;
        end else begin
            r_hold_full <= w_hold_full_next;
            if (w_hold_load) begin
                r_hold_data     <= P_DATA;
                r_hold_par_en   <= PAR_EN;
                r_hold_par_typ  <= PAR_TYP;
                r_hold_prescale <= Prescale;
            end
        end
    end
`else
    assign w_src_valid    = DATA_VALID;
    assign w_src_data     = P_DATA;
    assign w_src_par_en   = PAR_EN;
    assign w_src_par_typ  = PAR_TYP;
    assign w_src_prescale = Prescale;
    assign w_busy_next    = (w_state_next != IDLE);
`endif

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_bit_timer (
        .clk        (CLK),
        .rst_n      (RST),
        .i_enable   (r_state != IDLE),
        .i_eff      (r_eff),
        .o_bit_done (w_bit_done)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_idx_next    = r_idx;
        w_par_en_next = r_par_en;
        w_par_next    = r_par;
        w_eff_next    = r_eff;
        w_tx_next     = STOP_BIT;

        case (r_state)
            IDLE: ;
            START: begin
                if (w_bit_done) w_state_next = DATA;
            end
            DATA: begin
                if (w_bit_done) begin
                    w_shift_next = r_shift >> 1;
                    if (r_idx == c_IDX_W'(DATA_WIDTH - 1)) begin
                        w_idx_next   = '0;
                        w_state_next = r_par_en ? PARITY : STOP;
                    end else begin
                        w_idx_next = r_idx + c_IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (w_bit_done) w_state_next = STOP;
            end
            STOP: begin
                if (w_bit_done) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase

        if (w_launch) begin
            w_state_next  = START;
            w_shift_next  = w_src_data;
            w_idx_next    = '0;
            w_par_en_next = w_src_par_en;
            w_par_next    = (w_src_par_typ == PAR_ODD) ? ~^w_src_data : ^w_src_data;
            w_eff_next    = (w_src_prescale == '0) ? PRESCALE_WIDTH'(1) : w_src_prescale;
        end

        // The line register tracks the bit of the state being entered.
        case (w_state_next)
            START:   w_tx_next = START_BIT;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_par_next;
            default: w_tx_next = STOP_BIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_shift  <= '0;
            r_idx    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_eff    <= PRESCALE_WIDTH'(1);
            r_tx     <= STOP_BIT;
            r_busy   <= 1'b0;
        end else begin
            r_shift  <= w_shift_next;
            r_idx    <= w_idx_next;
            r_par_en <= w_par_en_next;
            r_par    <= w_par_next;
            r_eff    <= w_eff_next;
            r_tx     <= w_tx_next;
            r_busy   <= w_busy_next;
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule
`default_nettype wire
